// File: rtl/core_block_launcher.sv
// -----------------------------------------------------------------------------
// core_block_launcher
//
// Core-side responder to the GPU block dispatcher, one instance per core.
// It accepts a block assignment, launches the block's thread groups onto the
// core's warps (one warp per cycle), collects per-warp completions and returns
// a level core_done that stays high until reset or core_reset.
//
// Every output is registered and follows the FSM state by one cycle. A warp
// launched while the FSM handles warp index i shows its warp_start pulse in the
// cycle after that, and core_done rises the cycle after the FSM enters DONE.
//
// Ports
//   clk               in   rising-edge clock
//   reset             in   synchronous active-high global reset
//   core_reset        in   synchronous active-high per-core reset (same effect)
//   core_start        in   dispatch request, sampled only in IDLE
//   core_block_id     in   block index, valid with core_start
//   kernel_threads    in   total threads in the kernel, stable while busy
//   warp_start        out  one-hot, one-cycle launch pulse per warp
//   warp_thread_mask  out  active-lane mask of the launching warp, else 0
//   warp_base_thread  out  global thread index of lane 0, else 0
//   warp_done         in   per-warp completion (pulse or level)
//   busy              out  high while launching or waiting for completions
//   core_done         out  block complete, held until reset/core_reset
//   active_block_id   out  latched block id, 0 after reset
// -----------------------------------------------------------------------------
module core_block_launcher #(
   parameter int WARPS_PER_CORE   = 4,
   parameter int THREADS_PER_WARP = 32,
   parameter int THREAD_W         = 16
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        core_reset,
   input  logic                        core_start,
   input  logic [7:0]                  core_block_id,
   input  logic [THREAD_W-1:0]         kernel_threads,
   output logic [WARPS_PER_CORE-1:0]   warp_start,
   output logic [THREADS_PER_WARP-1:0] warp_thread_mask,
   output logic [THREAD_W-1:0]         warp_base_thread,
   input  logic [WARPS_PER_CORE-1:0]   warp_done,
   output logic                        busy,
   output logic                        core_done,
   output logic [7:0]                  active_block_id
);

   localparam int          IDX_W = (WARPS_PER_CORE > 1) ? $clog2(WARPS_PER_CORE) : 1;
   localparam logic [31:0] BT    = 32'(WARPS_PER_CORE * THREADS_PER_WARP);
   localparam logic [31:0] TPW   = 32'(THREADS_PER_WARP);

   typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, DONE} state_t;

   state_t                    state, state_nxt;
   logic [IDX_W-1:0]          idx;
   logic [31:0]               base;
   logic [WARPS_PER_CORE-1:0] launched, launched_nxt;
   logic [WARPS_PER_CORE-1:0] done_mask, done_nxt;

   // Per-warp launch arithmetic for the warp currently indexed by idx.
   logic [31:0]                 rem, warp_off, left, n_cur;
   logic [THREADS_PER_WARP-1:0] mask_cur;
   logic                        last_idx, launch_now;

   always_comb begin
      rem      = (32'(kernel_threads) > base) ? 32'(kernel_threads) - base : 32'd0;
      warp_off = 32'(idx) * TPW;
      // Saturate at 0 below the tail and clamp to a full warp above it.
      left     = (rem > warp_off) ? rem - warp_off : 32'd0;
      n_cur    = (left > TPW) ? TPW : left;
      // Shifting all-ones right keeps n_cur = THREADS_PER_WARP as all-ones
      // and n_cur = 0 as an empty mask without a wider intermediate.
      mask_cur = {THREADS_PER_WARP{1'b1}} >> (TPW - n_cur);
      last_idx = (idx == IDX_W'(WARPS_PER_CORE - 1));
   end

   // NOTE: every signal driven here gets a default first, so no path leaves a
   // value unassigned and no latch is inferred.
   always_comb begin
      state_nxt    = state;
      launched_nxt = launched;
      done_nxt     = done_mask;
      launch_now   = 1'b0;
      case (state)
         IDLE: begin
            if (core_start) begin
               state_nxt    = LAUNCH;
               launched_nxt = '0;
               done_nxt     = '0;
            end
         end
         LAUNCH: begin
            if (n_cur != 32'd0) begin
               launch_now        = 1'b1;
               launched_nxt[idx] = 1'b1;
            end
            // A completion counts if its warp launched earlier or launches now.
            done_nxt = done_mask | (warp_done & launched_nxt);
            if (last_idx) state_nxt = WAIT;
         end
         WAIT: begin
            done_nxt = done_mask | (warp_done & launched);
            if ((done_nxt & launched) == launched) state_nxt = DONE;
         end
         DONE:    state_nxt = DONE;
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: state is updated with non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (reset || core_reset) begin
         state            <= IDLE;
         idx              <= '0;
         base             <= '0;
         launched         <= '0;
         done_mask        <= '0;
         warp_start       <= '0;
         warp_thread_mask <= '0;
         warp_base_thread <= '0;
         busy             <= 1'b0;
         core_done        <= 1'b0;
         active_block_id  <= '0;
      end else begin
         state            <= state_nxt;
         launched         <= launched_nxt;
         done_mask        <= done_nxt;
         busy             <= (state == LAUNCH) || (state == WAIT);
         core_done        <= (state == DONE);
         warp_start       <= launch_now ? (WARPS_PER_CORE'(1) << idx) : '0;
         warp_thread_mask <= launch_now ? mask_cur : '0;
         warp_base_thread <= launch_now ? THREAD_W'(base + warp_off) : '0;
         if (state == IDLE && core_start) begin
            active_block_id <= core_block_id;
            base            <= 32'(core_block_id) * BT;
            idx             <= '0;
         end else if (state == LAUNCH) begin
            idx <= idx + 1'b1;
         end
      end
   end

endmodule
